// File: rtl/spw_link_fsm_pkg.sv
// SpaceWire link FSM shared types: state encoding, output bundle, default timing.
package spw_link_pkg;

    typedef enum logic [2:0] {
        ST_ERROR_RESET = 3'd0,
        ST_ERROR_WAIT  = 3'd1,
        ST_READY       = 3'd2,
        ST_STARTED     = 3'd3,
        ST_CONNECTING  = 3'd4,
        ST_RUN         = 3'd5
    } spw_state_e;

    // Moore output bundle, registered as a unit so every output moves on the same edge.
    typedef struct packed {
        logic rx_enable;
        logic tx_enable;
        logic send_null;
        logic send_fct;
        logic send_nchar;
        logic link_up;
    } spw_out_t;

    localparam int T_6U4_DEF     = 640;
    localparam int T_12U8_DEF    = 1280;
    localparam int ERR_CNT_W_DEF = 8;

    // Output decode for a given state; applied to the next state so outputs register with it.
    function automatic spw_out_t state_outputs(spw_state_e s);
        spw_out_t o;
        o            = '0;
        o.rx_enable  = (s != ST_ERROR_RESET);
        o.tx_enable  = (s == ST_STARTED) || (s == ST_CONNECTING) || (s == ST_RUN);
        o.send_null  = o.tx_enable;
        o.send_fct   = (s == ST_CONNECTING) || (s == ST_RUN);
        o.send_nchar = (s == ST_RUN);
        o.link_up    = (s == ST_RUN);
        return o;
    endfunction

endpackage

// File: rtl/spw_link_fsm_if.sv
// Link FSM control bundle: host/receiver/transmitter events in, link controls out.
interface spw_link_fsm_if
    import spw_link_pkg::*;
#(
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
);
    logic                 link_start;
    logic                 link_disable;
    logic                 auto_start;
    logic                 rx_got_null;
    logic                 rx_got_fct;
    logic                 rx_got_nchar;
    logic                 rx_got_time_code;
    logic                 rx_error;
    logic                 credit_error;
    logic                 rx_enable;
    logic                 tx_enable;
    logic                 send_null;
    logic                 send_fct;
    logic                 send_nchar;
    logic                 link_up;
    logic [2:0]           fsm_state;
    logic [ERR_CNT_W-1:0] error_count;

    // Environment side: host, receiver and transmitter.
    modport master (
        output link_start, link_disable, auto_start, rx_got_null, rx_got_fct,
               rx_got_nchar, rx_got_time_code, rx_error, credit_error,
        input  rx_enable, tx_enable, send_null, send_fct, send_nchar, link_up,
               fsm_state, error_count
    );

    // Link FSM side.
    modport slave (
        input  link_start, link_disable, auto_start, rx_got_null, rx_got_fct,
               rx_got_nchar, rx_got_time_code, rx_error, credit_error,
        output rx_enable, tx_enable, send_null, send_fct, send_nchar, link_up,
               fsm_state, error_count
    );
endinterface

// File: rtl/spw_link_fsm_timer.sv
// Restartable saturating up-counter timing the dwell in the current link state.
module spw_link_timer #(
    parameter int MAX = 1280
)(
    input  logic                       pclk,
    input  logic                       resetn,
    input  logic                       restart,
    output logic [$clog2(MAX+1)-1:0]   count
);
    localparam int             W    = $clog2(MAX + 1);
    localparam logic [W-1:0]   CMAX = W'(MAX);

    // Zero on restart, otherwise count up and hold at MAX.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn)
            count <= '0;
        else if (restart)
            count <= '0;
        else if (count != CMAX)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/spw_link_fsm.sv
// SpaceWire link-interface state machine: sequences receiver/transmitter enables,
// link-up and counts RUN exits caused by errors.
// Build option: define SPW_AUTO_START_EN to let auto_start plus a received NULL
// start the link; otherwise auto_start is ignored.
module spw_link_fsm
    import spw_link_pkg::*;
#(
    parameter int T_6U4     = T_6U4_DEF,
    parameter int T_12U8    = T_12U8_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
)(
    input  logic           pclk,
    input  logic           resetn,
    spw_link_fsm_if.slave  bus
);
    localparam int           TW  = $clog2(T_12U8 + 1);
    localparam logic [TW-1:0] C6  = TW'(T_6U4 - 1);
    localparam logic [TW-1:0] C12 = TW'(T_12U8 - 1);

    spw_state_e           r_state;
    spw_state_e           w_nxt;
    spw_out_t             r_out;
    logic                 r_got_null;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [TW-1:0]        w_tmr;
    logic                 w_restart;
    logic                 w_link_en;
    logic                 w_bad;
    logic                 w_conn_err;
    logic                 w_run_err;
    logic                 w_t6_hit;
    logic                 w_t12_hit;

`ifdef SPW_AUTO_START_EN
    assign w_link_en = !bus.link_disable &&
                       (bus.link_start || (bus.auto_start && r_got_null));
`else
    logic w_unused_auto;
    assign w_unused_auto = bus.auto_start;
    assign w_link_en     = !bus.link_disable && bus.link_start;
`endif

    // Any received character before the link is connecting is a protocol error.
    assign w_bad      = bus.rx_error || bus.rx_got_fct || bus.rx_got_nchar || bus.rx_got_time_code;
    // FCT is the advancing event in CONNECTING, so it is not an error there.
    assign w_conn_err = bus.rx_error || bus.rx_got_nchar || bus.rx_got_time_code || !w_link_en;
    assign w_run_err  = bus.rx_error || bus.credit_error || bus.link_disable;
    assign w_t6_hit   = (w_tmr == C6);
    assign w_t12_hit  = (w_tmr == C12);
    assign w_restart  = (w_nxt != r_state);

    spw_link_timer #(.MAX(T_12U8)) u_timer (
        .pclk    (pclk),
        .resetn  (resetn),
        .restart (w_restart),
        .count   (w_tmr)
    );

    // Next-state decision; errors outrank advancing events, advancing outranks timeout.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_ERROR_RESET: if (w_t6_hit) w_nxt = ST_ERROR_WAIT;
            ST_ERROR_WAIT: begin
                if (w_bad)          w_nxt = ST_ERROR_RESET;
                else if (w_t12_hit) w_nxt = ST_READY;
            end
            ST_READY: begin
                if (w_bad)          w_nxt = ST_ERROR_RESET;
                else if (w_link_en) w_nxt = ST_STARTED;
            end
            ST_STARTED: begin
                if (w_bad || !w_link_en)               w_nxt = ST_ERROR_RESET;
                else if (r_got_null || bus.rx_got_null) w_nxt = ST_CONNECTING;
                else if (w_t12_hit)                    w_nxt = ST_ERROR_RESET;
            end
            ST_CONNECTING: begin
                if (w_conn_err)          w_nxt = ST_ERROR_RESET;
                else if (bus.rx_got_fct) w_nxt = ST_RUN;
                else if (w_t12_hit)      w_nxt = ST_ERROR_RESET;
            end
            ST_RUN: if (w_run_err) w_nxt = ST_ERROR_RESET;
            default: w_nxt = ST_ERROR_RESET;
        endcase
    end

    // State, registered outputs, NULL-seen flag and saturating RUN-exit counter.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_ERROR_RESET;
            r_out      <= '0;
            r_got_null <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_nxt;
            r_out   <= state_outputs(w_nxt);
            if (w_nxt == ST_ERROR_RESET)
                r_got_null <= 1'b0;
            else if (bus.rx_got_null && r_out.rx_enable)
                r_got_null <= 1'b1;
            if (r_state == ST_RUN && w_nxt == ST_ERROR_RESET && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.rx_enable   = r_out.rx_enable;
    assign bus.tx_enable   = r_out.tx_enable;
    assign bus.send_null   = r_out.send_null;
    assign bus.send_fct    = r_out.send_fct;
    assign bus.send_nchar  = r_out.send_nchar;
    assign bus.link_up     = r_out.link_up;
    assign bus.fsm_state   = r_state;
    assign bus.error_count = r_err_cnt;
endmodule

// File: tb/tb_spw_link_fsm.sv
// Self-checking bench for spw_link_fsm: directed link scenarios plus random events,
// every cycle compared against a state/dwell reference model.
module tb_spw_link_fsm;
    localparam int T6   = 16;
    localparam int T12  = 32;
    localparam int ECW  = 8;
    localparam int EMAX = (1 << ECW) - 1;
`ifdef SPW_AUTO_START_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int S_ER = 0, S_EW = 1, S_RDY = 2, S_ST = 3, S_CN = 4, S_RUN = 5;

    logic pclk;
    logic resetn;
    int   n_chk;
    int   n_err;
    int   n;

    // reference model: current state, cycles since entry, NULL-seen, exit count
    int m_st;
    int m_t;
    bit m_gn;
    int m_err;

    spw_link_fsm_if #(.ERR_CNT_W(ECW)) bus ();

    spw_link_fsm #(.T_6U4(T6), .T_12U8(T12), .ERR_CNT_W(ECW)) dut (
        .pclk   (pclk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {15'd0, bus.fsm_state, bus.rx_enable, bus.tx_enable, bus.send_null,
                bus.send_fct, bus.send_nchar, bus.link_up, bus.error_count};
    endfunction

    function automatic logic [31:0] mdl_vec();
        logic [2:0] s;
        logic [7:0] e;
        bit active;
        s      = 3'(m_st);
        e      = 8'(m_err);
        active = (m_st >= S_ST);
        return {15'd0, s, (m_st != S_ER), active, active, (m_st >= S_CN),
                (m_st == S_RUN), (m_st == S_RUN), e};
    endfunction

    task automatic m_reset();
        m_st = S_ER; m_t = 0; m_gn = 0; m_err = 0;
    endtask

    // One clock of the link rules, using the inputs present at this edge.
    task automatic m_step();
        bit le, bad, err_c;
        int nx;
        le    = !bus.link_disable && (bus.link_start || (AUTO && bus.auto_start && m_gn));
        bad   = bus.rx_error || bus.rx_got_fct || bus.rx_got_nchar || bus.rx_got_time_code;
        err_c = bus.rx_error || bus.rx_got_nchar || bus.rx_got_time_code || !le;
        nx    = m_st;
        if (m_st == S_ER) begin
            if (m_t == T6 - 1) nx = S_EW;
        end else if (m_st == S_EW) begin
            if (bad) nx = S_ER; else if (m_t == T12 - 1) nx = S_RDY;
        end else if (m_st == S_RDY) begin
            if (bad) nx = S_ER; else if (le) nx = S_ST;
        end else if (m_st == S_ST) begin
            if (bad || !le) nx = S_ER;
            else if (m_gn || bus.rx_got_null) nx = S_CN;
            else if (m_t == T12 - 1) nx = S_ER;
        end else if (m_st == S_CN) begin
            if (err_c) nx = S_ER;
            else if (bus.rx_got_fct) nx = S_RUN;
            else if (m_t == T12 - 1) nx = S_ER;
        end else begin
            if (bus.rx_error || bus.credit_error || bus.link_disable) begin
                nx = S_ER;
                if (m_err < EMAX) m_err++;
            end
        end
        if (nx == S_ER) m_gn = 0;
        else if (bus.rx_got_null && m_st != S_ER) m_gn = 1;
        m_t  = (nx == m_st) ? m_t + 1 : 0;
        m_st = nx;
    endtask

    task automatic tick();
        @(posedge pclk);
        m_step();
        #1;
        chk($sformatf("cyc_st%0d", m_st), dut_vec(), mdl_vec());
    endtask

    task automatic dwell(input int st, output int cnt);
        cnt = 0;
        while (int'(bus.fsm_state) == st && cnt < 4000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic drive_to_run();
        int k;
        k = 0;
        while (m_st != S_RUN && k < 1000) begin
            bus.link_start  = 1'b1;
            bus.rx_got_null = (m_st == S_ST);
            bus.rx_got_fct  = (m_st == S_CN);
            tick();
            k++;
        end
        bus.rx_got_null = 1'b0;
        bus.rx_got_fct  = 1'b0;
        chk("to_run", 32'(bus.fsm_state), S_RUN);
    endtask

    task automatic clear_inputs();
        bus.link_start = 0; bus.link_disable = 0; bus.auto_start = 0;
        bus.rx_got_null = 0; bus.rx_got_fct = 0; bus.rx_got_nchar = 0;
        bus.rx_got_time_code = 0; bus.rx_error = 0; bus.credit_error = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        n_chk = 0; n_err = 0;
        clear_inputs();
        resetn = 1'b0;
        m_reset();
        #22;
        chk("rst_vec", dut_vec(), mdl_vec());
        chk("rst_state", 32'(bus.fsm_state), 0);
        resetn = 1'b1;

        // power-up sequence
        dwell(S_ER, n);  chk("er_dwell", n, T6);
        chk("rx_en_rise", 32'(bus.rx_enable), 1);
        dwell(S_EW, n);  chk("ew_dwell", n, T12);
        chk("ready", 32'(bus.fsm_state), S_RDY);
        chk("ready_tx_off", 32'(bus.tx_enable), 0);

        // STARTED without NULL times out
        bus.link_start = 1'b1;
        tick(); chk("started", 32'(bus.fsm_state), S_ST);
        dwell(S_ST, n); chk("st_timeout", n, T12);
        chk("to_er", 32'(bus.fsm_state), S_ER);
        chk("to_tx_off", 32'(bus.tx_enable), 0);
        bus.link_start = 1'b0;
        dwell(S_ER, n);  chk("er_dwell2", n, T6);
        dwell(S_EW, n);  chk("ew_dwell2", n, T12);

        // normal start-up to RUN
        bus.link_start = 1'b1;
        tick(); chk("st2", 32'(bus.fsm_state), S_ST);
        repeat (9) tick();
        bus.rx_got_null = 1'b1; tick(); bus.rx_got_null = 1'b0;
        chk("connecting", 32'(bus.fsm_state), S_CN);
        repeat (9) tick();
        bus.rx_got_fct = 1'b1; tick(); bus.rx_got_fct = 1'b0;
        chk("run", 32'(bus.fsm_state), S_RUN);
        chk("link_up", 32'(bus.link_up), 1);
        chk("send_nchar", 32'(bus.send_nchar), 1);

        // credit error exits and counter saturation
        bus.credit_error = 1'b1; tick(); bus.credit_error = 1'b0;
        chk("cerr_er", 32'(bus.fsm_state), S_ER);
        chk("cerr_cnt1", 32'(bus.error_count), 1);
        for (int i = 0; i < 255; i++) begin
            drive_to_run();
            bus.credit_error = 1'b1; tick(); bus.credit_error = 1'b0;
        end
        chk("err_sat", 32'(bus.error_count), EMAX);

        // FCT during ERROR_WAIT restarts the reset dwell
        bus.link_start = 1'b0;
        dwell(S_ER, n);
        repeat (10) tick();
        bus.rx_got_fct = 1'b1; tick(); bus.rx_got_fct = 1'b0;
        chk("ew_bad", 32'(bus.fsm_state), S_ER);
        dwell(S_ER, n);  chk("er_dwell3", n, T6);

        // auto-start on received NULL
        dwell(S_EW, n);
        bus.auto_start  = 1'b1;
        bus.rx_got_null = 1'b1; tick(); bus.rx_got_null = 1'b0;
        tick();
        chk("auto_start", 32'(bus.fsm_state), AUTO ? S_ST : S_RDY);
        repeat (3) tick();
        bus.auto_start = 1'b0;
        tick();

        // asynchronous reset from RUN
        drive_to_run();
        @(negedge pclk);
        #2 resetn = 1'b0;
        #1;
        m_reset();
        chk("async_vec", dut_vec(), mdl_vec());
        chk("async_cnt", 32'(bus.error_count), 0);
        clear_inputs();
        @(negedge pclk);
        resetn = 1'b1;

        // random events
        quiet = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) quiet = ($urandom_range(0, 3) != 0);
            bus.link_start       = ($urandom_range(0, 19) != 0);
            bus.link_disable     = ($urandom_range(0, 149) == 0);
            bus.auto_start       = $urandom_range(0, 1) != 0;
            bus.rx_got_null      = ($urandom_range(0, 7) == 0);
            bus.credit_error     = ($urandom_range(0, 99) == 0);
            if (quiet) begin
                bus.rx_got_fct       = (m_st == S_CN) && ($urandom_range(0, 9) == 0);
                bus.rx_got_nchar     = 1'b0;
                bus.rx_got_time_code = 1'b0;
                bus.rx_error         = 1'b0;
            end else begin
                bus.rx_got_fct       = ($urandom_range(0, 19) == 0);
                bus.rx_got_nchar     = ($urandom_range(0, 99) == 0);
                bus.rx_got_time_code = ($urandom_range(0, 99) == 0);
                bus.rx_error         = ($urandom_range(0, 149) == 0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
